flexbyte_pts_sr: RTL and testbench
==================================

# flexbyte_pts_sr

Parallel-to-serial byte shift register with a valid/ready handshake on both sides. It accepts one wide word (default 16 bytes, one AES block) and emits it as a sequence of narrower chunks (default 8 bytes), most- or least-significant chunk first. It sits on the output side of the AES datapath and feeds a narrower bus interface, complementing the serial-to-parallel gatherer on the input side.

## Interface
Parameters:
- MSB, 1: 1 = most-significant chunk emitted first; 0 = least-significant chunk first.
- NUM_BYTES_IN, 16: width in bytes of the loaded parallel word.
- NUM_BYTES_OUT, 8: width in bytes of each emitted chunk.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  data_in holds a word to load.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  NUM_BYTES_IN*8  parallel word.
- out_valid  output  1  data_out holds a valid chunk.
- out_ready  input  1  sink accepts the chunk this cycle.
- data_out  output  NUM_BYTES_OUT*8  current chunk.
- out_last  output  1  current chunk is the final chunk of the word.
- busy  output  1  a word is being serialized (state SHIFT).

## Operation
- BEATS = NUM_BYTES_IN / NUM_BYTES_OUT.
- Elaboration requires NUM_BYTES_IN > NUM_BYTES_OUT and NUM_BYTES_IN % NUM_BYTES_OUT == 0. Violating either is a $fatal.
- State: a shift register sr of NUM_BYTES_IN*8 bits, a beat counter cnt of max(1, $clog2(BEATS)) bits, and a 2-state FSM (IDLE, SHIFT).
- Load: `load_valid && load_ready` copies data_in into sr, clears cnt, and moves to SHIFT.
- data_out:
  - MSB=1: top chunk of sr (sr[NUM_BYTES_IN*8-1 -: NUM_BYTES_OUT*8]).
  - MSB=0: bottom chunk of sr (sr[NUM_BYTES_OUT*8-1:0]).
- Beat transfer: `out_valid && out_ready` shifts sr by NUM_BYTES_OUT*8 bits (left if MSB=1, right if MSB=0), zero-fills the vacated bits, and increments cnt.
- out_valid = (state == SHIFT). out_last = out_valid && (cnt == BEATS-1). busy = (state == SHIFT).
- On transfer of the last beat: go to IDLE, unless an overlap load occurs (see Configuration).
- After the final shift sr is all zeros, so data_out = 0 in IDLE.
- load_valid asserted while load_ready is low is ignored. No word is lost or corrupted.
- data_in is sampled only on an accepted load.

## Timing
- Reset (asynchronous): state=IDLE, sr=0, cnt=0.
  - Outputs after reset: load_ready=1, out_valid=0, out_last=0, busy=0, data_out=0.
- Latency: a load accepted at edge N presents the first chunk with out_valid=1 in the cycle after edge N.
- With out_ready held high, one beat transfers per cycle.
- Backpressure: while out_valid && !out_ready, data_out, out_last and cnt hold stable.
- load_ready = (state == IDLE) without the overlap feature.
- Throughput without overlap: BEATS+1 cycles per word.
- Reset mid-word aborts immediately. Remaining chunks are discarded and all outputs return to their reset values.

## Configuration
- Macro FLEXBYTE_PTS_SR_OVERLAP_EN.
- Defined:
  - load_ready = (state == IDLE) || (out_last && out_ready).
  - A load coinciding with the last-beat transfer reloads sr, clears cnt and stays in SHIFT.
  - Result is zero-bubble back-to-back words: BEATS cycles per word.
- Undefined:
  - load_ready is high only in IDLE.
  - Exactly one idle cycle separates consecutive words.

## Test plan
- Reset value check: assert n_rst low -> load_ready=1, out_valid=0, out_last=0, busy=0, data_out=0.
- Basic MSB=1, defaults: load 0x00112233445566778899AABBCCDDEEFF with out_ready=1 -> next cycle data_out=0x0011223344556677 with out_last=0, then 0x8899AABBCCDDEEFF with out_last=1, then out_valid=0 and load_ready=1.
- MSB=0, same word -> 0x8899AABBCCDDEEFF first, then 0x0011223344556677 with out_last=1.
- Backpressure: same load, out_ready low for 3 cycles on beat 0 -> data_out holds 0x0011223344556677 for all 3 cycles; a load_valid pulse while busy is ignored and the original beat 1 follows.
- Reset mid-word: n_rst pulsed after beat 0 transfers -> out_valid=0 and data_out=0 immediately; beat 1 is never emitted.
- Overlap, macro defined: second word 0xFFEEDDCCBBAA99887766554433221100 presented during the last beat of the first word -> its chunk 0xFFEEDDCCBBAA9988 appears the very next cycle, out_valid never deasserts. With the macro undefined, one out_valid=0 cycle appears between the words.

Source files
------------

// File: rtl/flexbyte_pts_sr.sv
// Purpose : parallel-to-serial byte shifter; loads one NUM_BYTES_IN-byte word and
//           emits it as BEATS = NUM_BYTES_IN/NUM_BYTES_OUT chunks, MSB- or LSB-chunk first.
// Latency : first chunk valid the cycle after load accept; one beat per cycle with out_ready high.
// Backpr. : out_valid && !out_ready holds data_out/out_last/cnt; load_ready low while serializing
//           (except on an accepted last beat when FLEXBYTE_PTS_SR_OVERLAP_EN is defined).
//
// Optional feature macro: FLEXBYTE_PTS_SR_OVERLAP_EN
//   defined   -> a new word may load on the same edge as the last-beat transfer
//                (zero-bubble, BEATS cycles per word).
//   undefined -> load only in IDLE (BEATS+1 cycles per word).
//
// Ports:
//   clk, n_rst            clock (rising edge), asynchronous active-low reset
//   load_valid/load_ready load handshake for data_in (NUM_BYTES_IN*8 bits)
//   out_valid/out_ready   chunk handshake for data_out (NUM_BYTES_OUT*8 bits)
//   out_last              current chunk is the final chunk of the word
//   busy                  a word is being serialized
module flexbyte_pts_sr #(
  parameter int MSB           = 1,
  parameter int NUM_BYTES_IN  = 16,
  parameter int NUM_BYTES_OUT = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [NUM_BYTES_IN*8-1:0]  data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_BYTES_OUT*8-1:0] data_out,
  output logic                       out_last,
  output logic                       busy
);

  localparam int W_IN  = NUM_BYTES_IN * 8;
  localparam int W_OUT = NUM_BYTES_OUT * 8;
  localparam int BEATS = NUM_BYTES_IN / NUM_BYTES_OUT;
  localparam int CW    = (BEATS > 2) ? $clog2(BEATS) : 1;

  // Reject configurations that cannot be split into whole chunks.
  if (NUM_BYTES_IN <= NUM_BYTES_OUT || (NUM_BYTES_IN % NUM_BYTES_OUT) != 0) begin : g_bad_cfg
    $fatal(1, "flexbyte_pts_sr: NUM_BYTES_IN must be a larger multiple of NUM_BYTES_OUT");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [W_IN-1:0] sr;
  logic [CW-1:0]   cnt;
  logic [W_IN-1:0] sr_next_beat;
  logic            is_last;

  assign is_last = (cnt == CW'(BEATS - 1));

  // Chunk selection and the shift direction both follow the emission order:
  // the chunk on data_out is always the one that the next shift discards.
  if (MSB != 0) begin : g_msb_first
    assign data_out     = sr[W_IN-1 -: W_OUT];
    assign sr_next_beat = sr << W_OUT;
  end else begin : g_lsb_first
    assign data_out     = sr[W_OUT-1:0];
    assign sr_next_beat = sr >> W_OUT;
  end

  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign out_last  = out_valid && is_last;

`ifdef FLEXBYTE_PTS_SR_OVERLAP_EN
  // Accepting the last beat frees the register on the same edge, so a new
  // word can take its place without an idle cycle.
  assign load_ready = (state == IDLE) || (out_last && out_ready);
`else
  assign load_ready = (state == IDLE);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            sr    <= data_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (is_last && load_valid && load_ready) begin
              // Overlap reload: only reachable when load_ready can rise in SHIFT.
              sr  <= data_in;
              cnt <= '0;
            end else begin
              // Zero-fill guarantees data_out reads 0 once the word has drained.
              sr <= sr_next_beat;
              if (is_last) begin
                cnt   <= '0;
                state <= IDLE;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flexbyte_pts_sr.sv
module tb_flexbyte_pts_sr;

  logic clk;
  logic n_rst;

  // Instance a: MSB chunk first.
  logic         a_load_valid, a_load_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [127:0] a_data_in;
  logic [63:0]  a_data_out;
  // Instance b: LSB chunk first.
  logic         b_load_valid, b_load_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [127:0] b_data_in;
  logic [63:0]  b_data_out;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] W1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] W2 = 128'hFFEEDDCCBBAA99887766554433221100;

  flexbyte_pts_sr #(.MSB(1), .NUM_BYTES_IN(16), .NUM_BYTES_OUT(8)) u_a (
    .clk(clk), .n_rst(n_rst),
    .load_valid(a_load_valid), .load_ready(a_load_ready), .data_in(a_data_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_data_out),
    .out_last(a_out_last), .busy(a_busy)
  );

  flexbyte_pts_sr #(.MSB(0), .NUM_BYTES_IN(16), .NUM_BYTES_OUT(8)) u_b (
    .clk(clk), .n_rst(n_rst),
    .load_valid(b_load_valid), .load_ready(b_load_ready), .data_in(b_data_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_data_out),
    .out_last(b_out_last), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; samples are taken 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_rst = 1'b0;
    a_load_valid = 1'b0; a_out_ready = 1'b0; a_data_in = '0;
    b_load_valid = 1'b0; b_out_ready = 1'b0; b_data_in = '0;
    #3;

    // ---------------- reset values ----------------
    chk1 ("rst_load_ready", a_load_ready, 1'b1);
    chk1 ("rst_out_valid",  a_out_valid,  1'b0);
    chk1 ("rst_out_last",   a_out_last,   1'b0);
    chk1 ("rst_busy",       a_busy,       1'b0);
    chk64("rst_data_out",   a_data_out,   64'h0);
    chk64("rst_b_data_out", b_data_out,   64'h0);
    #9;
    n_rst = 1'b1;
    tick();

    // ---------------- basic MSB=1 and MSB=0 ----------------
    a_load_valid = 1'b1; a_data_in = W1; a_out_ready = 1'b1;
    b_load_valid = 1'b1; b_data_in = W1; b_out_ready = 1'b1;
    tick();
    a_load_valid = 1'b0; b_load_valid = 1'b0;
    chk1 ("msb_b0_valid",  a_out_valid, 1'b1);
    chk1 ("msb_b0_busy",   a_busy,      1'b1);
    chk64("msb_b0_data",   a_data_out,  64'h0011223344556677);
    chk1 ("msb_b0_last",   a_out_last,  1'b0);
    chk1 ("msb_b0_lrdy",   a_load_ready, 1'b0);
    chk64("lsb_b0_data",   b_data_out,  64'h8899AABBCCDDEEFF);
    chk1 ("lsb_b0_last",   b_out_last,  1'b0);
    tick();
    chk64("msb_b1_data",   a_data_out,  64'h8899AABBCCDDEEFF);
    chk1 ("msb_b1_last",   a_out_last,  1'b1);
    chk64("lsb_b1_data",   b_data_out,  64'h0011223344556677);
    chk1 ("lsb_b1_last",   b_out_last,  1'b1);
    tick();
    chk1 ("msb_end_valid", a_out_valid,  1'b0);
    chk1 ("msb_end_lrdy",  a_load_ready, 1'b1);
    chk1 ("msb_end_busy",  a_busy,       1'b0);
    chk64("msb_end_data",  a_data_out,   64'h0);
    chk1 ("lsb_end_valid", b_out_valid,  1'b0);
    chk64("lsb_end_data",  b_data_out,   64'h0);

    // ---------------- backpressure + ignored load ----------------
    a_out_ready = 1'b0; a_load_valid = 1'b1; a_data_in = W1;
    tick();
    a_load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk64("bp_hold_data", a_data_out,   64'h0011223344556677);
      chk1 ("bp_hold_last", a_out_last,   1'b0);
      chk1 ("bp_hold_vld",  a_out_valid,  1'b1);
      chk1 ("bp_hold_lrdy", a_load_ready, 1'b0);
      if (i == 1) begin
        a_load_valid = 1'b1; a_data_in = W2;
      end else begin
        a_load_valid = 1'b0;
      end
      tick();
    end
    a_load_valid = 1'b0;
    chk64("bp_after_data", a_data_out, 64'h0011223344556677);
    a_out_ready = 1'b1;
    tick();
    chk64("bp_b1_data", a_data_out, 64'h8899AABBCCDDEEFF);
    chk1 ("bp_b1_last", a_out_last, 1'b1);
    tick();
    chk1 ("bp_end_valid", a_out_valid, 1'b0);

    // ---------------- reset mid-word ----------------
    a_load_valid = 1'b1; a_data_in = W1;
    tick();
    a_load_valid = 1'b0;
    chk64("mr_b0_data", a_data_out, 64'h0011223344556677);
    tick();
    chk64("mr_b1_data", a_data_out, 64'h8899AABBCCDDEEFF);
    n_rst = 1'b0;
    #1;
    chk1 ("mr_valid", a_out_valid,  1'b0);
    chk64("mr_data",  a_data_out,   64'h0);
    chk1 ("mr_last",  a_out_last,   1'b0);
    chk1 ("mr_busy",  a_busy,       1'b0);
    chk1 ("mr_lrdy",  a_load_ready, 1'b1);
    #2;
    n_rst = 1'b1;
    tick();
    chk1 ("mr_post_valid", a_out_valid, 1'b0);
    chk64("mr_post_data",  a_data_out,  64'h0);

    // ---------------- back-to-back words ----------------
    a_load_valid = 1'b1; a_data_in = W1;
    tick();
    a_load_valid = 1'b0;
    chk64("bb_w1b0_data", a_data_out, 64'h0011223344556677);
    tick();
    chk1 ("bb_w1b1_last", a_out_last, 1'b1);
    a_load_valid = 1'b1; a_data_in = W2;
`ifdef FLEXBYTE_PTS_SR_OVERLAP_EN
    chk1 ("bb_lrdy_last", a_load_ready, 1'b1);
    tick();
    a_load_valid = 1'b0;
    chk1 ("bb_w2b0_valid", a_out_valid, 1'b1);
    chk64("bb_w2b0_data",  a_data_out,  64'hFFEEDDCCBBAA9988);
    chk1 ("bb_w2b0_last",  a_out_last,  1'b0);
`else
    chk1 ("bb_lrdy_last", a_load_ready, 1'b0);
    tick();
    chk1 ("bb_gap_valid", a_out_valid,  1'b0);
    chk1 ("bb_gap_lrdy",  a_load_ready, 1'b1);
    tick();
    a_load_valid = 1'b0;
    chk1 ("bb_w2b0_valid", a_out_valid, 1'b1);
    chk64("bb_w2b0_data",  a_data_out,  64'hFFEEDDCCBBAA9988);
    chk1 ("bb_w2b0_last",  a_out_last,  1'b0);
`endif
    tick();
    chk64("bb_w2b1_data", a_data_out, 64'h7766554433221100);
    chk1 ("bb_w2b1_last", a_out_last, 1'b1);
    tick();
    chk1 ("bb_end_valid", a_out_valid, 1'b0);
    chk64("bb_end_data",  a_data_out,  64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
